mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 40 ++++
 rtl/mult_div_unit_if.sv | 39 +++
 rtl/mdu_iter_step.sv | 56 +++++
 rtl/mult_div_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit_pkg
//  Description : Shared definitions for the multiply/divide unit. Holds the
//                op encodings used by the decode/ALU-control logic, the FSM
//                state encoding, the default operand width and the
//                iteration-counter width.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_div_unit_pkg;

    localparam int C_WIDTH_DEFAULT = 32;
    localparam int C_CNT_W         = 6;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIX  = 2'b11
    } mdu_state_e;

    // op[1] selects divide, op[0] selects the unsigned variant
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit_if
//  Description : Pipeline-side bundle of the multiply/divide unit.
//  Ports       : master - pipeline side (drives start/op/A/B/hi_we/lo_we/wdata)
//                slave  - unit side (drives hi/lo/busy/done/div_by_zero)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_div_unit_if
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = C_WIDTH_DEFAULT
) ();

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, op, A, B, hi_we, lo_we, wdata,
        input  hi, lo, busy, done, div_by_zero
    );

    modport slave (
        input  start, op, A, B, hi_we, lo_we, wdata,
        output hi, lo, busy, done, div_by_zero
    );

endinterface
`default_nettype wire

// File: rtl/mdu_iter_step.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_iter_step
//  Description : One combinational iteration of the multiply/divide datapath.
//                mode_i=0 : unsigned shift-add multiply step on {hi,lo}
//                mode_i=1 : restoring-division step on {remainder,quotient}
//  Ports       : mode_i        - 0 multiply, 1 divide
//                hi_i/lo_i     - current working pair
//                m_i           - multiplicand or divisor magnitude
//                hi_o/lo_o     - working pair after this step
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter_step
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = C_WIDTH_DEFAULT
) (
    input  wire logic             mode_i,
    input  wire logic [WIDTH-1:0] hi_i,
    input  wire logic [WIDTH-1:0] lo_i,
    input  wire logic [WIDTH-1:0] m_i,
    output logic      [WIDTH-1:0] hi_o,
    output logic      [WIDTH-1:0] lo_o
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH+1:0] w_diff;
    logic             w_ge;
    logic             w_unused;

    // Multiply: add multiplicand when the current multiplier bit is set,
    // then shift the whole {carry,hi,lo} right by one.
    assign w_sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : {(WIDTH+1){1'b0}});

    // Divide: bring the next dividend bit into the remainder and try a
    // subtraction; the extra top bit of w_diff is the borrow.
    assign w_shl  = {hi_i, lo_i[WIDTH-1]};
    assign w_diff = {1'b0, w_shl} - {2'b00, m_i};
    assign w_ge   = ~w_diff[WIDTH+1];

    // The remainder stays below the divisor, so bit WIDTH of a
    // non-negative difference is always zero.
    assign w_unused = w_diff[WIDTH];

    always_comb begin
        hi_o = w_sum[WIDTH:1];
        lo_o = {w_sum[0], lo_i[WIDTH-1:1]};
        if (mode_i) begin
            hi_o = w_ge ? w_diff[WIDTH-1:0] : w_shl[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], w_ge};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Iterative multiply/divide unit with architectural HI/LO.
//                Signed ops work on magnitudes; the sign is applied in FIX.
//                Results reach hi/lo only on the FIX->IDLE edge.
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous active-high reset
//                mdu        - slave side of mult_div_unit_if (start, op, A, B,
//                             hi_we, lo_we, wdata in; hi, lo, busy, done,
//                             div_by_zero out)
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = C_WIDTH_DEFAULT
) (
    input  wire logic      clk,
    input  wire logic      rst,
    mult_div_unit_if.slave mdu
);

    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(WIDTH - 1);

    mdu_state_e         state_q, state_d;
    logic [C_CNT_W-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   hi_q, lo_q;      // architectural HI/LO
    logic [WIDTH-1:0]   acc_q, wrk_q;    // working pair (upper / lower)
    logic [WIDTH-1:0]   mc_q;            // multiplicand or divisor magnitude
    logic               is_div_q;
    logic               res_neg_q;       // product / quotient is negative
    logic               rem_neg_q;       // remainder takes dividend sign
    logic               dbz_q;

    logic               w_accept;
    logic               w_mt_ok;
    logic               w_div;
    logic               w_b_zero;
    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [WIDTH-1:0]   w_step_hi, w_step_lo;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;
    logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

    assign w_accept = (state_q == IDLE) && mdu.start;
    assign w_mt_ok  = (state_q == IDLE) && !mdu.start;
    assign w_div    = op_is_div(mdu.op);
    assign w_b_zero = (mdu.B == '0);
    assign w_a_neg  = op_is_signed(mdu.op) && mdu.A[WIDTH-1];
    assign w_b_neg  = op_is_signed(mdu.op) && mdu.B[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -mdu.A : mdu.A;
    assign w_b_mag  = w_b_neg ? -mdu.B : mdu.B;

    mdu_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mode_i (state_q == DIV),
        .hi_i   (acc_q),
        .lo_i   (wrk_q),
        .m_i    (mc_q),
        .hi_o   (w_step_hi),
        .lo_o   (w_step_lo)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (mdu.start) begin
                    if (!w_div)        state_d = MUL;
                    else if (w_b_zero) state_d = FIX;   // no iterations needed
                    else               state_d = DIV;
                end
            end
            MUL, DIV: begin
                cnt_d = cnt_q + C_CNT_W'(1);
                if (cnt_q == C_LAST) begin
                    state_d = FIX;
                    cnt_d   = '0;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Sign fix-up of the finished magnitudes
    // ------------------------------------------------------------------
    assign w_prod     = {acc_q, wrk_q};
    assign w_prod_fix = res_neg_q ? -w_prod : w_prod;

    always_comb begin
        w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod_fix[WIDTH-1:0];
        if (dbz_q) begin
            // working pair was preloaded with A / all ones at acceptance
            w_fix_hi = acc_q;
            w_fix_lo = wrk_q;
        end else if (is_div_q) begin
            w_fix_hi = rem_neg_q ? -acc_q : acc_q;
            w_fix_lo = res_neg_q ? -wrk_q : wrk_q;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and architectural registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            wrk_q     <= '0;
            mc_q      <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            if (w_accept) begin
                is_div_q  <= w_div;
                res_neg_q <= w_a_neg ^ w_b_neg;
                rem_neg_q <= w_a_neg;
                dbz_q     <= w_div && w_b_zero;
                if (!w_div) begin
                    acc_q <= '0;
                    wrk_q <= w_b_mag;
                    mc_q  <= w_a_mag;
                end else if (w_b_zero) begin
                    acc_q <= mdu.A;
                    wrk_q <= '1;
                    mc_q  <= '0;
                end else begin
                    acc_q <= '0;
                    wrk_q <= w_a_mag;
                    mc_q  <= w_b_mag;
                end
            end else if ((state_q == MUL) || (state_q == DIV)) begin
                acc_q <= w_step_hi;
                wrk_q <= w_step_lo;
            end

            if (state_q == FIX) begin
                hi_q <= w_fix_hi;
                lo_q <= w_fix_lo;
            end else if (w_mt_ok) begin
                if (mdu.hi_we) hi_q <= mdu.wdata;
                if (mdu.lo_we) lo_q <= mdu.wdata;
            end
        end
    end

    assign mdu.hi          = hi_q;
    assign mdu.lo          = lo_q;
    assign mdu.busy        = (state_q != IDLE);
    assign mdu.done        = done_q;
    assign mdu.div_by_zero = dbz_q;

endmodule
`default_nettype wire
